// File: rtl/sd_resp_receiver_if.sv
// sd_resp_receiver_if: sequencer <-> receiver bundle for CMD-line responses.
// master = command sequencer side, slave = response receiver side.
interface sd_resp_receiver_if;
  logic         bit_en;
  logic         cmd_in;
  logic         start;
  logic [1:0]   resp_type;
  logic         r2_sel;
  logic [5:0]   cmd_index;
  logic         busy;
  logic         done;
  logic         timeout;
  logic         crc_err;
  logic         end_err;
  logic         index_err;
  logic [127:0] resp_data;
  logic         cid_en;
  logic         csd_en;
  logic         ocr_en;
  logic         rca_en;

  modport master (
    output bit_en, cmd_in, start,
    output resp_type, r2_sel, cmd_index,
    input  busy, done, timeout,
    input  crc_err, end_err, index_err,
    input  resp_data,
    input  cid_en, csd_en, ocr_en, rca_en
  );

  modport slave (
    input  bit_en, cmd_in, start,
    input  resp_type, r2_sel, cmd_index,
    output busy, done, timeout,
    output crc_err, end_err, index_err,
    output resp_data,
    output cid_en, csd_en, ocr_en, rca_en
  );
endinterface

// File: rtl/sd_resp_receiver.sv
// sd_resp_receiver: captures R1/R2/R3/R6 frames from CMD, checks and decodes.
// Build option: define SD_RESP_CRC_EN to include the CRC7 check and crc_err.
module sd_resp_receiver #(
  parameter int NCR_MAX = 64
) (
  input logic               clk,
  input logic               reset,
  sd_resp_receiver_if.slave bus
);
  localparam int WW = (NCR_MAX > 1) ? $clog2(NCR_MAX) : 1;
  localparam logic [1:0] R1 = 2'd0;
  localparam logic [1:0] R2 = 2'd1;
  localparam logic [1:0] R3 = 2'd2;
  localparam logic [1:0] R6 = 2'd3;

  typedef enum logic [1:0] {
    IDLE, WAIT_START, SHIFT, CHECK
  } state_t;

  state_t        state;
  logic [1:0]    type_q;
  logic          sel_q;
  logic [5:0]    idx_q;
  logic [7:0]    cnt;
  logic [WW-1:0] wait_cnt;
  // start bit is always 0 and never stored
  logic [133:0]  sr;
  logic [134:0]  sr_nx;
  logic          is_r2;
  logic          last;
  logic          tx_bad;
  logic          end_bad;
  logic          idx_bad;
  logic          crc_bad;
  logic          any_bad;

  assign is_r2   = type_q == R2;
  assign sr_nx   = {sr, bus.cmd_in};
  assign last    = cnt == (is_r2 ? 8'd135 : 8'd47);
  assign tx_bad  = is_r2 ? sr_nx[134] : sr_nx[46];
  assign end_bad = tx_bad | ~bus.cmd_in;
  assign idx_bad = (type_q == R1 || type_q == R6)
                && sr_nx[45:40] != idx_q;
  assign any_bad = end_bad | idx_bad | crc_bad;

`ifdef SD_RESP_CRC_EN
  logic [6:0] crc;
  logic [7:0] pos;
  logic       take;
  logic       in_rng;
  logic       fb;

  assign pos    = (state == SHIFT) ? cnt : 8'd0;
  assign take   = bus.bit_en
               && (state == SHIFT
               || (state == WAIT_START && !bus.cmd_in));
  assign in_rng = is_r2 ? (pos >= 8'd8 && pos < 8'd128)
                        : (pos < 8'd40);
  assign fb     = crc[6] ^ bus.cmd_in;

  always_ff @(posedge clk) begin
    if (!reset || (state == IDLE && bus.start))
      crc <= '0;
    else if (take && in_rng)
      crc <= {crc[5:0], 1'b0} ^ {3'b0, fb, 2'b0, fb};
  end

  // received CRC sits at frame bits len-8..len-2, i.e. sr[6:0] at the end bit
  assign crc_bad = type_q != R3 && sr[6:0] != crc;
`else
  assign crc_bad = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      state         <= IDLE;
      type_q        <= R1;
      sel_q         <= 1'b0;
      idx_q         <= '0;
      cnt           <= '0;
      wait_cnt      <= '0;
      sr            <= '0;
      bus.busy      <= 1'b0;
      bus.done      <= 1'b0;
      bus.timeout   <= 1'b0;
      bus.crc_err   <= 1'b0;
      bus.end_err   <= 1'b0;
      bus.index_err <= 1'b0;
      bus.resp_data <= '0;
      bus.cid_en    <= 1'b0;
      bus.csd_en    <= 1'b0;
      bus.ocr_en    <= 1'b0;
      bus.rca_en    <= 1'b0;
    end else begin
      unique case (state)
        IDLE: if (bus.start) begin
          type_q        <= bus.resp_type;
          sel_q         <= bus.r2_sel;
          idx_q         <= bus.cmd_index;
          cnt           <= '0;
          wait_cnt      <= '0;
          sr            <= '0;
          bus.timeout   <= 1'b0;
          bus.crc_err   <= 1'b0;
          bus.end_err   <= 1'b0;
          bus.index_err <= 1'b0;
          bus.resp_data <= '0;
          bus.busy      <= 1'b1;
          state         <= WAIT_START;
        end
        WAIT_START: if (bus.bit_en) begin
          if (!bus.cmd_in) begin
            cnt   <= 8'd1;
            state <= SHIFT;
          end else if (wait_cnt == WW'(NCR_MAX - 1)) begin
            bus.busy    <= 1'b0;
            bus.done    <= 1'b1;
            bus.timeout <= 1'b1;
            state       <= CHECK;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        SHIFT: if (bus.bit_en) begin
          sr  <= sr_nx[133:0];
          cnt <= cnt + 8'd1;
          if (last) begin
            bus.busy      <= 1'b0;
            bus.done      <= 1'b1;
            bus.end_err   <= end_bad;
            bus.index_err <= idx_bad;
            bus.crc_err   <= crc_bad;
            bus.resp_data <= is_r2 ? sr_nx[127:0]
                                   : {96'b0, sr_nx[39:8]};
            if (!any_bad) begin
              unique case (1'b1)
                (is_r2 && !sel_q): bus.cid_en <= 1'b1;
                (is_r2 && sel_q):  bus.csd_en <= 1'b1;
                (type_q == R3):    bus.ocr_en <= 1'b1;
                (type_q == R6):    bus.rca_en <= 1'b1;
                default: ;
              endcase
            end
            state <= CHECK;
          end
        end
        CHECK: begin
          bus.done   <= 1'b0;
          bus.cid_en <= 1'b0;
          bus.csd_en <= 1'b0;
          bus.ocr_en <= 1'b0;
          bus.rca_en <= 1'b0;
          state      <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_sd_resp_receiver.sv
// tb_sd_resp_receiver: directed frames with bench-built CRC7 and expected status.
// Status vector order: busy done timeout crc end idx cid csd ocr rca.
module tb_sd_resp_receiver;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   done_cnt = 0;
  int   dc;
  logic [9:0]   st;
  logic [119:0] cid;
  logic [119:0] csd;
  logic [135:0] ones;

  sd_resp_receiver_if bus();

  sd_resp_receiver #(.NCR_MAX(64)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (bus.done) done_cnt++;

  assign st = {bus.busy, bus.done, bus.timeout,
               bus.crc_err, bus.end_err, bus.index_err,
               bus.cid_en, bus.csd_en, bus.ocr_en, bus.rca_en};

  task automatic chk(input string tag,
                     input logic [127:0] got,
                     input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic [6:0] crc7(input logic [119:0] d,
                                      input int n);
    logic [6:0] c;
    logic fb;
    c = '0;
    for (int i = n - 1; i >= 0; i--) begin
      fb = c[6] ^ d[i];
      c = {c[5:0], 1'b0};
      if (fb) c = c ^ 7'h09;
    end
    return c;
  endfunction

  function automatic logic [135:0] f48(input logic [5:0] idx,
                                       input logic [31:0] arg);
    logic [39:0] h;
    h = {2'b00, idx, arg};
    return {88'b0, h, crc7({80'b0, h}, 40), 1'b1};
  endfunction

  function automatic logic [135:0] f136(input logic [119:0] r);
    return {2'b00, 6'h3F, r, crc7(r, 120), 1'b1};
  endfunction

  task automatic arm(input logic [1:0] t, input logic sel,
                     input logic [5:0] idx, input logic glitch);
    bus.resp_type = t;
    bus.r2_sel    = sel;
    bus.cmd_index = idx;
    bus.start     = 1'b1;
    bus.bit_en    = glitch;
    bus.cmd_in    = !glitch;
    tick(1);
    bus.start  = 1'b0;
    bus.bit_en = 1'b0;
    bus.cmd_in = 1'b1;
    chk("busy_after_start", bus.busy, 1);
  endtask

  task automatic send(input logic [135:0] f, input int n,
                      input int gap);
    for (int i = n - 1; i >= 0; i--) begin
      if (i == 0) chk("done_early", bus.done, 0);
      bus.cmd_in = f[i];
      bus.bit_en = 1'b1;
      tick(1);
      bus.bit_en = 1'b0;
      bus.cmd_in = 1'b1;
      if (i > 0) tick(gap - 1);
    end
  endtask

  initial begin
    bus.bit_en    = 1'b0;
    bus.cmd_in    = 1'b1;
    bus.start     = 1'b0;
    bus.resp_type = 2'd0;
    bus.r2_sel    = 1'b0;
    bus.cmd_index = 6'd0;
    ones = '1;
    cid  = 120'h03_5344_5344_3136_4780_1234_5678_0142;
    csd  = 120'h40_0E00_325B_5900_003B_377F_800A_4040;
    tick(3);
    chk("rst_status", st, 0);
    chk("rst_data", bus.resp_data, 0);
    reset = 1'b1;
    tick(2);

    arm(2'd3, 1'b0, 6'd3, 1'b0);
    send(f48(6'd3, 32'h12340500), 48, 1);
    chk("r6_status", st, 10'b0100000001);
    chk("r6_data", bus.resp_data, 128'h12340500);
    tick(1);
    chk("r6_after", st, 0);

    arm(2'd1, 1'b0, 6'd0, 1'b0);
    send(f136(cid), 136, 1);
    chk("cid_status", st, 10'b0100001000);
    chk("cid_data", bus.resp_data, {cid, crc7(cid, 120), 1'b1});
    tick(1);
    chk("cid_after", st, 0);

    arm(2'd1, 1'b1, 6'd0, 1'b0);
    send(f136(csd), 136, 1);
    chk("csd_status", st, 10'b0100000100);
    chk("csd_data", bus.resp_data, {csd, crc7(csd, 120), 1'b1});

    tick(1);
    arm(2'd2, 1'b0, 6'd0, 1'b0);
    send({88'b0, 2'b00, 6'h3F, 32'h80FF8000, 7'h7F, 1'b1}, 48, 4);
    chk("r3_status", st, 10'b0100000010);
    chk("r3_data", bus.resp_data, 128'h80FF8000);

    tick(1);
    arm(2'd0, 1'b0, 6'd17, 1'b0);
    send(f48(6'd17, 32'h00000900) ^ 136'd2, 48, 1);
`ifdef SD_RESP_CRC_EN
    chk("r1_crc_status", st, 10'b0101000000);
`else
    chk("r1_crc_status", st, 10'b0100000000);
`endif
    chk("r1_data", bus.resp_data, 128'h900);

    tick(1);
    arm(2'd0, 1'b0, 6'd17, 1'b1);
    send(f48(6'd18, 32'h00000900), 48, 1);
    chk("r1_idx_status", st, 10'b0100010000);
    tick(1);
    chk("r1_idx_hold", st, 10'b0000010000);

    arm(2'd3, 1'b0, 6'd3, 1'b0);
    send(f48(6'd3, 32'h12340500) & ~136'd1, 48, 2);
    chk("r6_end_status", st, 10'b0100100000);

    tick(1);
    arm(2'd3, 1'b0, 6'd3, 1'b0);
    send(ones, 10, 1);
    bus.resp_type = 2'd1;
    bus.start = 1'b1;
    tick(1);
    bus.start = 1'b0;
    chk("to_second_start", st, 10'b1000000000);
    send(ones, 53, 1);
    chk("to_before", st, 10'b1000000000);
    send(ones, 1, 1);
    chk("to_status", st, 10'b0110000000);
    chk("to_data", bus.resp_data, 0);

    tick(1);
    arm(2'd1, 1'b0, 6'd0, 1'b0);
    send(f136(cid) >> 86, 50, 1);
    dc = done_cnt;
    reset = 1'b0;
    tick(2);
    chk("midrst_status", st, 0);
    chk("midrst_data", bus.resp_data, 0);
    reset = 1'b1;
    tick(2);
    chk("midrst_nodone", done_cnt, dc);

    arm(2'd3, 1'b0, 6'd7, 1'b0);
    send(f48(6'd7, 32'hBEEF0000), 48, 1);
    chk("post_r6_status", st, 10'b0100000001);
    chk("post_r6_data", bus.resp_data, 128'hBEEF0000);
    tick(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
